// File: rtl/simt_pkg.sv
// Shared types for the SIMT reconvergence stack: entry kinds, entry
// layout, per-warp event codes and same-warp arbitration priorities.
package simt_pkg;

   typedef enum logic [1:0] {
      ENT_JOIN = 2'd0,
      ENT_ELSE = 2'd1,
      ENT_CALL = 2'd2
   } entry_kind_t;

   // Fields sized for the widest supported config (threads, PC <= 32);
   // narrower builds zero-extend on push and truncate on pop.
   localparam int ENT_MASK_W = 32;
   localparam int ENT_PC_W   = 32;

   typedef struct packed {
      entry_kind_t            kind;
      logic [ENT_MASK_W-1:0]  mask;
      logic [ENT_PC_W-1:0]    pc;
   } entry_t;

   // Event delivered to one warp after arbitration.
   typedef enum logic [2:0] {
      EV_NONE, EV_INIT, EV_BR, EV_SYNC, EV_RET, EV_CALL
   } ev_t;

   // Same-warp priority: higher index wins.
   localparam int NUM_PRIO  = 5;
   localparam int PRIO_CALL = 0;
   localparam int PRIO_RET  = 1;
   localparam int PRIO_SYNC = 2;
   localparam int PRIO_BR   = 3;
   localparam int PRIO_INIT = 4;

endpackage

// File: rtl/simt_stack_gen_if.sv
// Event and status bus between Decode/EX, the SIMT stack and Fetch/IBuffer.
interface simt_stack_gen_if #(
   parameter int NUM_WARPS   = 8,
   parameter int NUM_THREADS = 8,
   parameter int PC_W        = 10
);
   localparam int WID_W = $clog2(NUM_WARPS);

   logic                          init_valid;
   logic [WID_W-1:0]              init_warp;
   logic [NUM_THREADS-1:0]        init_mask;
   logic                          br_valid;
   logic [WID_W-1:0]              br_warp;
   logic [NUM_THREADS-1:0]        br_outcome;
   logic [PC_W-1:0]               br_target;
   logic [PC_W-1:0]               br_fallthru;
   logic                          sync_valid;
   logic [WID_W-1:0]              sync_warp;
   logic                          call_valid;
   logic [WID_W-1:0]              call_warp;
   logic [PC_W-1:0]               call_ret_pc;
   logic                          ret_valid;
   logic [WID_W-1:0]              ret_warp;

   logic [NUM_WARPS*NUM_THREADS-1:0] am_flat;
   logic [NUM_WARPS-1:0]             redirect_valid;
   logic [NUM_WARPS*PC_W-1:0]        redirect_pc_flat;
   logic [NUM_WARPS-1:0]             drop_instr;
   logic [NUM_WARPS-1:0]             err_overflow;
   logic [NUM_WARPS-1:0]             err_underflow;
   logic [NUM_WARPS-1:0]             err_mismatch;
   logic                             conflict_err;

   modport master (
      output init_valid, init_warp, init_mask,
      output br_valid, br_warp, br_outcome, br_target, br_fallthru,
      output sync_valid, sync_warp,
      output call_valid, call_warp, call_ret_pc,
      output ret_valid, ret_warp,
      input  am_flat, redirect_valid, redirect_pc_flat, drop_instr,
      input  err_overflow, err_underflow, err_mismatch, conflict_err
   );

   modport slave (
      input  init_valid, init_warp, init_mask,
      input  br_valid, br_warp, br_outcome, br_target, br_fallthru,
      input  sync_valid, sync_warp,
      input  call_valid, call_warp, call_ret_pc,
      input  ret_valid, ret_warp,
      output am_flat, redirect_valid, redirect_pc_flat, drop_instr,
      output err_overflow, err_underflow, err_mismatch, conflict_err
   );
endinterface

// File: rtl/simt_warp_stack.sv
// One warp's reconvergence stack: active mask, stack pointer, entries,
// sticky error flags and the registered redirect/drop pulse.
module simt_warp_stack
   import simt_pkg::*;
#(
   parameter int NUM_THREADS = 8,
   parameter int DEPTH       = 4,
   parameter int PC_W        = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  ev_t                    ev,
   input  logic [NUM_THREADS-1:0] init_mask,
   input  logic [NUM_THREADS-1:0] br_outcome,
   input  logic [PC_W-1:0]        br_target,
   input  logic [PC_W-1:0]        br_fallthru,
   input  logic [PC_W-1:0]        call_ret_pc,
   output logic [NUM_THREADS-1:0] am,
   output logic                   redirect_valid,
   output logic [PC_W-1:0]        redirect_pc,
   output logic                   drop,
   output logic                   err_overflow,
   output logic                   err_underflow,
   output logic                   err_mismatch
);
   localparam int SP_W = $clog2(DEPTH + 1);
   localparam int IX_W = $clog2(DEPTH);
   localparam logic [SP_W-1:0] SP_FULL    = SP_W'(DEPTH);
   localparam logic [SP_W-1:0] SP_DIV_MAX = SP_W'(DEPTH - 2);

   entry_t                 stk [DEPTH];
   logic [SP_W-1:0]        sp;
   logic [SP_W-1:0]        sp_m1;
   logic [IX_W-1:0]        top_ix, push_ix, push_ix1;
   logic [NUM_THREADS-1:0] taken;
   entry_kind_t            top_kind;
   logic                   empty;

   assign sp_m1    = sp - SP_W'(1);
   assign top_ix   = sp_m1[IX_W-1:0];
   assign push_ix  = sp[IX_W-1:0];
   assign push_ix1 = push_ix + IX_W'(1);
   assign taken    = br_outcome & am;
   assign top_kind = stk[top_ix].kind;
   assign empty    = (sp == '0);

   // Apply the arbitrated event; redirect/drop are one-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         am             <= '0;
         sp             <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         drop           <= 1'b0;
         err_overflow   <= 1'b0;
         err_underflow  <= 1'b0;
         err_mismatch   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      end else begin
         redirect_valid <= 1'b0;
         drop           <= 1'b0;
         case (ev)
            EV_INIT: begin
               am            <= init_mask;
               sp            <= '0;
               err_overflow  <= 1'b0;
               err_underflow <= 1'b0;
               err_mismatch  <= 1'b0;
            end
            EV_BR: begin
               if (taken == am) begin
                  redirect_valid <= 1'b1;
                  redirect_pc    <= br_target;
                  drop           <= 1'b1;
               end else if (taken != '0) begin
                  // Divergence needs two free slots: JOIN below ELSE.
                  if (sp > SP_DIV_MAX) begin
                     err_overflow <= 1'b1;
                  end else begin
                     stk[push_ix]  <= '{kind: ENT_JOIN, mask: ENT_MASK_W'(am), pc: '0};
                     stk[push_ix1] <= '{kind: ENT_ELSE, mask: ENT_MASK_W'(am & ~taken),
                                        pc: ENT_PC_W'(br_fallthru)};
                     sp             <= sp + SP_W'(2);
                     am             <= taken;
                     redirect_valid <= 1'b1;
                     redirect_pc    <= br_target;
                     drop           <= 1'b1;
                  end
               end
            end
            EV_SYNC: begin
               if (empty) begin
                  err_underflow <= 1'b1;
               end else if (top_kind == ENT_CALL) begin
                  err_mismatch <= 1'b1;
               end else begin
                  sp <= sp_m1;
                  am <= stk[top_ix].mask[NUM_THREADS-1:0];
                  if (top_kind == ENT_ELSE) begin
                     redirect_valid <= 1'b1;
                     redirect_pc    <= stk[top_ix].pc[PC_W-1:0];
                     drop           <= 1'b1;
                  end
               end
            end
            EV_RET: begin
               if (empty) begin
                  err_underflow <= 1'b1;
               end else if (top_kind != ENT_CALL) begin
                  err_mismatch <= 1'b1;
               end else begin
                  sp             <= sp_m1;
                  am             <= stk[top_ix].mask[NUM_THREADS-1:0];
                  redirect_valid <= 1'b1;
                  redirect_pc    <= stk[top_ix].pc[PC_W-1:0];
                  drop           <= 1'b1;
               end
            end
            EV_CALL: begin
               if (sp == SP_FULL) begin
                  err_overflow <= 1'b1;
               end else begin
                  stk[push_ix] <= '{kind: ENT_CALL, mask: ENT_MASK_W'(am),
                                    pc: ENT_PC_W'(call_ret_pc)};
                  sp           <= sp + SP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/simt_stack_gen.sv
// Per-warp SIMT reconvergence stack: warp-ID decode, same-warp
// arbitration and one simt_warp_stack per warp.
module simt_stack_gen
   import simt_pkg::*;
#(
   parameter int NUM_WARPS   = 8,
   parameter int NUM_THREADS = 8,
   parameter int DEPTH       = 4,
   parameter int PC_W        = 10
) (
   input logic          clk,
   input logic          rst,
   simt_stack_gen_if.slave bus
);
   localparam int WID_W = $clog2(NUM_WARPS);

   logic [NUM_WARPS-1:0][NUM_THREADS-1:0] am_pk;
   logic [NUM_WARPS-1:0][PC_W-1:0]        rpc_pk;
   logic [NUM_WARPS-1:0]                  multi;
   logic                                  conflict_q;

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
      logic [NUM_PRIO-1:0] req;
      ev_t                 ev;

      assign req[PRIO_INIT] = bus.init_valid && (bus.init_warp == WID_W'(w));
      assign req[PRIO_BR]   = bus.br_valid   && (bus.br_warp   == WID_W'(w));
      assign req[PRIO_SYNC] = bus.sync_valid && (bus.sync_warp == WID_W'(w));
      assign req[PRIO_RET]  = bus.ret_valid  && (bus.ret_warp  == WID_W'(w));
      assign req[PRIO_CALL] = bus.call_valid && (bus.call_warp == WID_W'(w));
      assign multi[w]       = ($countones(req) > 1);

      // Highest-priority request wins; later assignments override earlier.
      always_comb begin
         ev = EV_NONE;
         if (req[PRIO_CALL]) ev = EV_CALL;
         if (req[PRIO_RET])  ev = EV_RET;
         if (req[PRIO_SYNC]) ev = EV_SYNC;
         if (req[PRIO_BR])   ev = EV_BR;
         if (req[PRIO_INIT]) ev = EV_INIT;
      end

      simt_warp_stack #(
         .NUM_THREADS (NUM_THREADS),
         .DEPTH       (DEPTH),
         .PC_W        (PC_W)
      ) u_stack (
         .clk            (clk),
         .rst            (rst),
         .ev             (ev),
         .init_mask      (bus.init_mask),
         .br_outcome     (bus.br_outcome),
         .br_target      (bus.br_target),
         .br_fallthru    (bus.br_fallthru),
         .call_ret_pc    (bus.call_ret_pc),
         .am             (am_pk[w]),
         .redirect_valid (bus.redirect_valid[w]),
         .redirect_pc    (rpc_pk[w]),
         .drop           (bus.drop_instr[w]),
         .err_overflow   (bus.err_overflow[w]),
         .err_underflow  (bus.err_underflow[w]),
         .err_mismatch   (bus.err_mismatch[w])
      );
   end

   assign bus.am_flat          = am_pk;
   assign bus.redirect_pc_flat = rpc_pk;
   assign bus.conflict_err     = conflict_q;

   // Discarded same-warp events are reported in the same cycle as the results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) conflict_q <= 1'b0;
      else     conflict_q <= |multi;
   end
endmodule

// File: tb/tb_simt_stack_gen.sv
// Self-checking bench for simt_stack_gen: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_simt_stack_gen;
   localparam int NW = 8, NT = 8, D = 4, PW = 10, WW = 3;
   localparam int E_NONE = 0, E_INIT = 1, E_BR = 2, E_SYNC = 3, E_RET = 4, E_CALL = 5;
   localparam int K_JOIN = 0, K_ELSE = 1, K_CALL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   tot_cnt  = 0;

   always #5 clk = ~clk;

   simt_stack_gen_if #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_W(PW)) bus ();

   simt_stack_gen #(.NUM_WARPS(NW), .NUM_THREADS(NT), .DEPTH(D), .PC_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Behavioural model: per-warp mask, explicit stack of (kind, mask, pc).
   logic [NT-1:0] m_am   [NW];
   int            m_sp   [NW];
   int            m_kind [NW][D];
   logic [NT-1:0] m_mask [NW][D];
   logic [PW-1:0] m_pc   [NW][D];
   logic [PW-1:0] m_rpc  [NW];
   bit m_ovf [NW], m_udf [NW], m_mis [NW], m_rv [NW], m_drop [NW];
   bit m_conf;

   function automatic logic [NT-1:0] am_of(int w);
      return bus.am_flat[w*NT +: NT];
   endfunction

   function automatic logic [PW-1:0] rpc_of(int w);
      return bus.redirect_pc_flat[w*PW +: PW];
   endfunction

   task automatic model_reset();
      for (int w = 0; w < NW; w++) begin
         m_am[w] = '0; m_sp[w] = 0; m_rpc[w] = '0;
         m_ovf[w] = 0; m_udf[w] = 0; m_mis[w] = 0; m_rv[w] = 0; m_drop[w] = 0;
      end
      m_conf = 0;
   endtask

   task automatic m_push(int w, int k, logic [NT-1:0] mk, logic [PW-1:0] pc);
      m_kind[w][m_sp[w]] = k; m_mask[w][m_sp[w]] = mk; m_pc[w][m_sp[w]] = pc;
      m_sp[w]++;
   endtask

   task automatic m_redir(int w, logic [PW-1:0] pc);
      m_rv[w] = 1; m_drop[w] = 1; m_rpc[w] = pc;
   endtask

   task automatic m_apply(int w, int ev);
      logic [NT-1:0] tk;
      int t;
      case (ev)
         E_INIT: begin
            m_am[w] = bus.init_mask; m_sp[w] = 0; m_ovf[w] = 0; m_udf[w] = 0; m_mis[w] = 0;
         end
         E_BR: begin
            tk = bus.br_outcome & m_am[w];
            if (tk == m_am[w]) m_redir(w, bus.br_target);
            else if (tk != 0) begin
               if (m_sp[w] + 2 > D) m_ovf[w] = 1;
               else begin
                  m_push(w, K_JOIN, m_am[w], '0);
                  m_push(w, K_ELSE, m_am[w] & ~tk, bus.br_fallthru);
                  m_am[w] = tk;
                  m_redir(w, bus.br_target);
               end
            end
         end
         E_SYNC, E_RET: begin
            if (m_sp[w] == 0) m_udf[w] = 1;
            else begin
               t = m_sp[w] - 1;
               if ((ev == E_SYNC) == (m_kind[w][t] == K_CALL)) m_mis[w] = 1;
               else begin
                  m_sp[w] = t;
                  m_am[w] = m_mask[w][t];
                  if (m_kind[w][t] != K_JOIN) m_redir(w, m_pc[w][t]);
               end
            end
         end
         E_CALL: begin
            if (m_sp[w] == D) m_ovf[w] = 1;
            else m_push(w, K_CALL, m_am[w], bus.call_ret_pc);
         end
         default: ;
      endcase
   endtask

   // Arbitrate the currently driven events the way the spec orders them.
   task automatic model_step();
      bit conf = 0;
      for (int w = 0; w < NW; w++) begin
         int n = 0;
         int ev = E_NONE;
         m_rv[w] = 0; m_drop[w] = 0;
         if (bus.call_valid && bus.call_warp == w) begin n++; ev = E_CALL; end
         if (bus.ret_valid  && bus.ret_warp  == w) begin n++; ev = E_RET;  end
         if (bus.sync_valid && bus.sync_warp == w) begin n++; ev = E_SYNC; end
         if (bus.br_valid   && bus.br_warp   == w) begin n++; ev = E_BR;   end
         if (bus.init_valid && bus.init_warp == w) begin n++; ev = E_INIT; end
         if (n > 1) conf = 1;
         if (ev != E_NONE) m_apply(w, ev);
      end
      m_conf = conf;
   endtask

   task automatic clear_inputs();
      bus.init_valid = 0; bus.br_valid = 0; bus.sync_valid = 0;
      bus.call_valid = 0; bus.ret_valid = 0;
   endtask

   task automatic drv_init(int w, logic [NT-1:0] m);
      bus.init_valid = 1; bus.init_warp = WW'(w); bus.init_mask = m;
   endtask
   task automatic drv_br(int w, logic [NT-1:0] o, logic [PW-1:0] t, logic [PW-1:0] f);
      bus.br_valid = 1; bus.br_warp = WW'(w); bus.br_outcome = o;
      bus.br_target = t; bus.br_fallthru = f;
   endtask
   task automatic drv_sync(int w);
      bus.sync_valid = 1; bus.sync_warp = WW'(w);
   endtask
   task automatic drv_call(int w, logic [PW-1:0] pc);
      bus.call_valid = 1; bus.call_warp = WW'(w); bus.call_ret_pc = pc;
   endtask
   task automatic drv_ret(int w);
      bus.ret_valid = 1; bus.ret_warp = WW'(w);
   endtask

   // Inputs are driven just after a falling edge; results sampled at the next one.
   task automatic step();
      model_step();
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset();
      rst = 1;
      clear_inputs();
      bus.init_warp = '0; bus.init_mask = '0; bus.br_warp = '0; bus.br_outcome = '0;
      bus.br_target = '0; bus.br_fallthru = '0; bus.sync_warp = '0;
      bus.call_warp = '0; bus.call_ret_pc = '0; bus.ret_warp = '0;
      repeat (2) @(negedge clk);
      tot_cnt++; if (bus.am_flat !== '0) $display("FAIL reset_am got %h want 0", bus.am_flat); else pass_cnt++;
      tot_cnt++; if (bus.redirect_valid !== '0 || bus.drop_instr !== '0 || bus.conflict_err !== 1'b0)
         $display("FAIL reset_pulses got rv=%h drop=%h conf=%b want 0", bus.redirect_valid, bus.drop_instr, bus.conflict_err);
      else pass_cnt++;
      tot_cnt++; if (bus.redirect_pc_flat !== '0) $display("FAIL reset_rpc got %h want 0", bus.redirect_pc_flat); else pass_cnt++;
      tot_cnt++; if ((bus.err_overflow | bus.err_underflow | bus.err_mismatch) !== '0)
         $display("FAIL reset_err got %h/%h/%h want 0", bus.err_overflow, bus.err_underflow, bus.err_mismatch);
      else pass_cnt++;
      rst = 0;
      model_reset();
   endtask

   task automatic test_divergence();
      drv_init(0, 8'hFF); step();
      tot_cnt++; if (am_of(0) !== 8'hFF) $display("FAIL init_am got %h want ff", am_of(0)); else pass_cnt++;
      drv_br(0, 8'h0F, 10'h040, 10'h024); step();
      tot_cnt++; if (am_of(0) !== 8'h0F) $display("FAIL div_am got %h want 0f", am_of(0)); else pass_cnt++;
      tot_cnt++; if (bus.redirect_valid[0] !== 1'b1 || rpc_of(0) !== 10'h040 || bus.drop_instr[0] !== 1'b1)
         $display("FAIL div_redirect got v=%b pc=%h drop=%b want 1/040/1", bus.redirect_valid[0], rpc_of(0), bus.drop_instr[0]);
      else pass_cnt++;
      step();
      tot_cnt++; if (bus.redirect_valid[0] !== 1'b0 || bus.drop_instr[0] !== 1'b0 || rpc_of(0) !== 10'h040)
         $display("FAIL pulse_hold got v=%b drop=%b pc=%h want 0/0/040", bus.redirect_valid[0], bus.drop_instr[0], rpc_of(0));
      else pass_cnt++;
      drv_sync(0); step();
      tot_cnt++; if (am_of(0) !== 8'hF0 || bus.redirect_valid[0] !== 1'b1 || rpc_of(0) !== 10'h024)
         $display("FAIL sync_else got am=%h v=%b pc=%h want f0/1/024", am_of(0), bus.redirect_valid[0], rpc_of(0));
      else pass_cnt++;
      drv_sync(0); step();
      tot_cnt++; if (am_of(0) !== 8'hFF || bus.redirect_valid[0] !== 1'b0)
         $display("FAIL sync_join got am=%h v=%b want ff/0", am_of(0), bus.redirect_valid[0]);
      else pass_cnt++;
      drv_sync(0); step();
      tot_cnt++; if (bus.err_underflow[0] !== 1'b1 || am_of(0) !== 8'hFF)
         $display("FAIL sync_empty got udf=%b am=%h want 1/ff", bus.err_underflow[0], am_of(0));
      else pass_cnt++;
   endtask

   task automatic test_uniform();
      drv_init(3, 8'h33); step();
      drv_br(3, 8'h33, 10'h155, 10'h0AA); step();
      tot_cnt++; if (am_of(3) !== 8'h33 || bus.redirect_valid[3] !== 1'b1 || rpc_of(3) !== 10'h155 || bus.drop_instr[3] !== 1'b1)
         $display("FAIL uni_taken got am=%h v=%b pc=%h d=%b want 33/1/155/1", am_of(3), bus.redirect_valid[3], rpc_of(3), bus.drop_instr[3]);
      else pass_cnt++;
      drv_br(3, 8'hCC, 10'h077, 10'h0AA); step();
      tot_cnt++; if (am_of(3) !== 8'h33 || bus.redirect_valid[3] !== 1'b0 || bus.drop_instr[3] !== 1'b0)
         $display("FAIL uni_not_taken got am=%h v=%b d=%b want 33/0/0", am_of(3), bus.redirect_valid[3], bus.drop_instr[3]);
      else pass_cnt++;
      drv_ret(3); step();
      tot_cnt++; if (bus.err_underflow[3] !== 1'b1) $display("FAIL uni_sp0 got udf=%b want 1", bus.err_underflow[3]); else pass_cnt++;
   endtask

   task automatic test_overflow();
      drv_init(1, 8'hFF); step();
      drv_br(1, 8'h0F, 10'h100, 10'h104); step();
      drv_br(1, 8'h03, 10'h200, 10'h204); step();
      drv_br(1, 8'h01, 10'h300, 10'h304); step();
      tot_cnt++; if (bus.err_overflow[1] !== 1'b1 || am_of(1) !== 8'h03 || bus.redirect_valid[1] !== 1'b0)
         $display("FAIL ovf_div got ovf=%b am=%h v=%b want 1/03/0", bus.err_overflow[1], am_of(1), bus.redirect_valid[1]);
      else pass_cnt++;
      drv_sync(1); step();
      tot_cnt++; if (am_of(1) !== 8'h0C || rpc_of(1) !== 10'h204 || bus.redirect_valid[1] !== 1'b1)
         $display("FAIL ovf_sp_kept got am=%h pc=%h v=%b want 0c/204/1", am_of(1), rpc_of(1), bus.redirect_valid[1]);
      else pass_cnt++;
      drv_init(1, 8'h81); step();
      tot_cnt++; if (bus.err_overflow[1] !== 1'b0 || am_of(1) !== 8'h81)
         $display("FAIL ovf_clear got ovf=%b am=%h want 0/81", bus.err_overflow[1], am_of(1));
      else pass_cnt++;
   endtask

   task automatic test_call_ret();
      drv_init(2, 8'hFF); step();
      drv_br(2, 8'hF0, 10'h050, 10'h060); step();
      drv_call(2, 10'h080); step();
      tot_cnt++; if (am_of(2) !== 8'hF0 || bus.redirect_valid[2] !== 1'b0)
         $display("FAIL call_am got am=%h v=%b want f0/0", am_of(2), bus.redirect_valid[2]);
      else pass_cnt++;
      drv_sync(2); step();
      tot_cnt++; if (bus.err_mismatch[2] !== 1'b1 || am_of(2) !== 8'hF0)
         $display("FAIL sync_on_call got mis=%b am=%h want 1/f0", bus.err_mismatch[2], am_of(2));
      else pass_cnt++;
      drv_ret(2); step();
      tot_cnt++; if (am_of(2) !== 8'hF0 || bus.redirect_valid[2] !== 1'b1 || rpc_of(2) !== 10'h080 || bus.drop_instr[2] !== 1'b1)
         $display("FAIL ret got am=%h v=%b pc=%h d=%b want f0/1/080/1", am_of(2), bus.redirect_valid[2], rpc_of(2), bus.drop_instr[2]);
      else pass_cnt++;
      drv_ret(2); step();
      tot_cnt++; if (bus.err_mismatch[2] !== 1'b1 || am_of(2) !== 8'hF0 || bus.redirect_valid[2] !== 1'b0)
         $display("FAIL ret_on_else got mis=%b am=%h v=%b want 1/f0/0", bus.err_mismatch[2], am_of(2), bus.redirect_valid[2]);
      else pass_cnt++;
   endtask

   task automatic test_conflict();
      drv_init(5, 8'hFF); step();
      drv_br(5, 8'h0F, 10'h123, 10'h127); drv_sync(5); drv_init(6, 8'hAA); step();
      tot_cnt++; if (bus.conflict_err !== 1'b1) $display("FAIL conflict got %b want 1", bus.conflict_err); else pass_cnt++;
      tot_cnt++; if (am_of(5) !== 8'h0F || rpc_of(5) !== 10'h123 || am_of(6) !== 8'hAA)
         $display("FAIL conflict_apply got am5=%h pc5=%h am6=%h want 0f/123/aa", am_of(5), rpc_of(5), am_of(6));
      else pass_cnt++;
      step();
      tot_cnt++; if (bus.conflict_err !== 1'b0) $display("FAIL conflict_pulse got %b want 0", bus.conflict_err); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      drv_init(4, 8'hFF); step();
      drv_br(4, 8'h3C, 10'h010, 10'h014); step();
      drv_br(4, 8'h0C, 10'h020, 10'h024); step();
      drv_sync(4); step();
      tot_cnt++; if (am_of(4) !== 8'h30 || rpc_of(4) !== 10'h024)
         $display("FAIL b2b_else got am=%h pc=%h want 30/024", am_of(4), rpc_of(4));
      else pass_cnt++;
      drv_sync(4); step();
      drv_sync(4); step();
      tot_cnt++; if (am_of(4) !== 8'hC3 || rpc_of(4) !== 10'h014 || bus.redirect_valid[4] !== 1'b1)
         $display("FAIL b2b_outer got am=%h pc=%h v=%b want c3/014/1", am_of(4), rpc_of(4), bus.redirect_valid[4]);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [NW*NT-1:0] e_am;
      logic [NW*PW-1:0] e_rpc;
      logic [NW-1:0]    e_rv, e_dr, e_ov, e_ud, e_mi;
      for (int w = 0; w < NW; w++) begin
         drv_init(w, NT'($urandom_range(1, 255))); step();
      end
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 7) == 0) drv_init($urandom_range(0, 3), NT'($urandom_range(1, 255)));
         if ($urandom_range(0, 1) == 0) drv_br($urandom_range(0, 3), NT'($urandom), PW'($urandom), PW'($urandom));
         if ($urandom_range(0, 2) == 0) drv_sync($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) drv_ret($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) drv_call($urandom_range(0, 3), PW'($urandom));
         step();
         for (int w = 0; w < NW; w++) begin
            e_am[w*NT +: NT] = m_am[w];
            e_rpc[w*PW +: PW] = m_rpc[w];
            e_rv[w] = m_rv[w]; e_dr[w] = m_drop[w];
            e_ov[w] = m_ovf[w]; e_ud[w] = m_udf[w]; e_mi[w] = m_mis[w];
         end
         tot_cnt++; if (bus.am_flat !== e_am) $display("FAIL rnd_am c%0d got %h want %h", c, bus.am_flat, e_am); else pass_cnt++;
         tot_cnt++; if (bus.redirect_valid !== e_rv || bus.drop_instr !== e_dr)
            $display("FAIL rnd_pulse c%0d got %h/%h want %h/%h", c, bus.redirect_valid, bus.drop_instr, e_rv, e_dr);
         else pass_cnt++;
         tot_cnt++; if (bus.redirect_pc_flat !== e_rpc) $display("FAIL rnd_rpc c%0d got %h want %h", c, bus.redirect_pc_flat, e_rpc); else pass_cnt++;
         tot_cnt++; if (bus.err_overflow !== e_ov || bus.err_underflow !== e_ud || bus.err_mismatch !== e_mi)
            $display("FAIL rnd_err c%0d got %h/%h/%h want %h/%h/%h", c, bus.err_overflow, bus.err_underflow,
                     bus.err_mismatch, e_ov, e_ud, e_mi);
         else pass_cnt++;
         tot_cnt++; if (bus.conflict_err !== m_conf) $display("FAIL rnd_conf c%0d got %b want %b", c, bus.conflict_err, m_conf); else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      drv_init(7, 8'hFF); step();
      drv_br(7, 8'h0F, 10'h011, 10'h015); step();
      #2 rst = 1;
      #1;
      tot_cnt++; if (bus.redirect_valid !== '0 || bus.drop_instr !== '0 || bus.am_flat !== '0 || bus.redirect_pc_flat !== '0)
         $display("FAIL mid_reset got rv=%h drop=%h am=%h rpc=%h want 0", bus.redirect_valid, bus.drop_instr,
                  bus.am_flat, bus.redirect_pc_flat);
      else pass_cnt++;
      @(negedge clk);
      rst = 0;
      model_reset();
      drv_sync(7); step();
      tot_cnt++; if (bus.err_underflow[7] !== 1'b1) $display("FAIL mid_reset_sp got udf=%b want 1", bus.err_underflow[7]); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_divergence();
      test_uniform();
      test_overflow();
      test_call_ret();
      test_conflict();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule

// File: doc/simt_stack_gen.md
# simt_stack_gen

Parametrised per-warp SIMT reconvergence stack, successor of the fixed 8-warp/8-thread SIMT block. It sits between Decode/EX and Fetch/IBuffer. It tracks each warp's active mask across divergent branches, sync (.S) points, and call/return, and issues PC redirects plus younger-instruction drops. New over the predecessor: configurable warps, threads, depth and PC width; call/return nesting mixed with divergence; sticky overflow/underflow/mismatch error status; and a defined same-warp collision priority.

## Interface
- NUM_WARPS, 8, warp count (power of 2); WID_W = $clog2(NUM_WARPS)
- NUM_THREADS, 8, threads per warp (active-mask width)
- DEPTH, 4, stack entries per warp (≥2)
- PC_W, 10, instruction address width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- init_valid / init_warp / init_mask  in  1 / WID_W / NUM_THREADS  Task Manager warp launch
- br_valid / br_warp / br_outcome  in  1 / WID_W / NUM_THREADS  EX conditional-branch resolution, per-thread taken bits
- br_target / br_fallthru  in  PC_W each  taken PC and PC+4 of the branch
- sync_valid / sync_warp  in  1 / WID_W  .S instruction at decode
- call_valid / call_warp / call_ret_pc  in  1 / WID_W / PC_W  call at decode, return address
- ret_valid / ret_warp  in  1 / WID_W  return at decode
- am_flat  out  NUM_WARPS*NUM_THREADS  active mask per warp, warp w at [w*T +: T]
- redirect_valid  out  NUM_WARPS  one-cycle PC-update pulse to Fetch
- redirect_pc_flat  out  NUM_WARPS*PC_W  redirect target per warp
- drop_instr  out  NUM_WARPS  one-cycle pulse: IBuffer flushes the warp's younger instructions
- err_overflow / err_underflow / err_mismatch  out  NUM_WARPS each  sticky per-warp error flags
- conflict_err  out  1  pulse: lower-priority same-warp event discarded

## Operation
- Entry = {kind ∈ JOIN, ELSE, CALL; mask[T]; pc[PC_W]}. Per-warp stack pointer sp is 0..DEPTH.
- init: am = init_mask, sp = 0, all three err flags of that warp cleared.
- Branch: taken = br_outcome & am.
  - taken == am: uniform taken. Redirect to br_target, drop, no push.
  - taken == 0: uniform not-taken. No action.
  - Otherwise divergent, needs 2 free entries. Push JOIN{am, –}, then ELSE{am & ~taken, br_fallthru}. Set am = taken, redirect to br_target, drop.
  - If sp > DEPTH-2: set err_overflow, state unchanged, no redirect.
- sync: if top is ELSE, pop it, set am = its mask, redirect to its pc, drop. If top is JOIN, pop it, set am = its mask, no redirect. If top is CALL or sp == 0, set err_mismatch / err_underflow and leave state unchanged.
- call: if sp == DEPTH, set err_overflow. Otherwise push CALL{am, call_ret_pc}; am is unchanged. Fetch handles the jump itself.
- ret: if top is CALL, pop it, set am = its mask, redirect to its pc, drop. Top not CALL sets err_mismatch; sp == 0 sets err_underflow. State is unchanged in both error cases.
- Different warps may each take one event in the same cycle, all applied.
- Same-warp priority: init > br > sync > ret > call. Losers are discarded and conflict_err pulses.
- A warp whose err flag is set still processes events normally.

## Timing
- Event at edge N: am, sp and stack updated at edge N+1. redirect_valid, redirect_pc and drop_instr are registered and high for exactly cycle N+1.
- Back-to-back events on the same warp every cycle are supported; each event sees the state written by the previous one.
- Reset values: am_flat = 0, every sp = 0, redirect_valid = 0, redirect_pc_flat = 0, drop_instr = 0, all err flags = 0, conflict_err = 0.
- Reset asserted mid-operation clears everything asynchronously; no pending redirect survives.
- redirect_pc holds its last value when redirect_valid is 0.

## Structure
- Shared package simt_pkg holds: entry-kind enum (JOIN = 2'd0, ELSE = 2'd1, CALL = 2'd2), entry struct typedef, and event-priority constants.
- Sub-module simt_warp_stack contains one warp's stack, sp, am, err flags and redirect registers. It is instantiated NUM_WARPS times via generate.
- The top level does warp-ID decode and same-warp arbitration.

## Test plan
- Reset, then init warp 0 with mask 8'hFF; branch with outcome 8'h0F, target 0x40, fallthru 0x24 -> cycle+1: am 8'h0F, redirect 0x40, drop[0]=1, sp=2.
- Continue that sequence: sync -> am 8'hF0, redirect 0x24. Sync again -> am 8'hFF, no redirect, sp=0.
- Warp 3 with mask 8'h33, outcome 8'h33 -> redirect to target, sp stays 0. Then outcome 8'hCC -> no action.
- DEPTH=4, warp 1: two divergent branches fill the stack. A third divergent branch -> err_overflow[1]=1, am and sp unchanged. A following init clears the flag.
- Warp 2: call with ret_pc 0x80 after a divergent branch, then sync -> err_mismatch[2]. Ret -> am restored, redirect 0x80.
- Same cycle: br and sync on warp 5 plus init on warp 6 -> br applied on 5, sync discarded, conflict_err=1, warp 6 initialised.
